fpu_result_writeback: RTL

Write-back stage on the consumer side of the 64-bit vector FPU's exception/output stage. Accepts each completed result with its 5-bit exception vector and an issue tag, buffers it in a small first-word-fall-through FIFO for the register-file write port, and accumulates IEEE sticky status flags. Unmasked exceptions trigger a precise trap sequence: the block stalls the FPU, drains older results, then raises a trap to the sequencer until it is acknowledged.

---
 rtl/fpu_result_writeback.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fpu_result_writeback.sv
// FPU result write-back: FWFT result FIFO, sticky IEEE flags and an optional precise-trap
// sequencer (RUN -> DRAIN -> TRAP), compiled in when FPU_WB_TRAP_EN is defined.
module fpu_result_writeback #(
    parameter int BIT_WIDTH  = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [BIT_WIDTH-1:0] i_result,
    input  logic [4:0]           i_exception,
    input  logic [TAG_WIDTH-1:0] i_tag,
    output logic                 o_wb_valid,
    input  logic                 i_wb_ready,
    output logic [BIT_WIDTH-1:0] o_wb_data,
    output logic [TAG_WIDTH-1:0] o_wb_tag,
    output logic [4:0]           o_wb_exc,
    input  logic [4:0]           i_trap_mask,
    output logic [4:0]           o_sticky,
    input  logic [4:0]           i_sticky_clr,
    output logic                 o_trap,
    output logic [TAG_WIDTH-1:0] o_trap_tag,
    output logic [4:0]           o_trap_flags,
    input  logic                 i_trap_ack
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [BIT_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0] tag_mem  [FIFO_DEPTH];
    logic [4:0]           exc_mem  [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    sticky_q, sticky_d;
    logic          run_ok;
    logic          accept;
    logic          pop;

    assign accept = i_valid & o_ready;
    assign pop    = o_wb_valid & i_wb_ready;

    // Gated with rst_n so the block advertises nothing while held in reset.
    assign o_ready = rst_n & run_ok & (count_q < DEPTH_C);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A flag raised by the accepting result beats a simultaneous clear.
        sticky_d = (sticky_q & ~i_sticky_clr) | (accept ? i_exception : 5'b0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_mem[wr_ptr_q] <= i_result;
            tag_mem[wr_ptr_q]  <= i_tag;
            exc_mem[wr_ptr_q]  <= i_exception;
        end
    end

    // Storage is never reset, so the head is masked to zero whenever the FIFO is empty.
    assign o_wb_valid = (count_q != '0);
    assign o_wb_data  = o_wb_valid ? data_mem[rd_ptr_q] : '0;
    assign o_wb_tag   = o_wb_valid ? tag_mem[rd_ptr_q]  : '0;
    assign o_wb_exc   = o_wb_valid ? exc_mem[rd_ptr_q]  : '0;
    assign o_sticky   = sticky_q;

`ifdef FPU_WB_TRAP_EN
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    state_t                state_q;
    logic                  trap_q;
    logic [TAG_WIDTH-1:0]  trap_tag_q;
    logic [4:0]            trap_flags_q;
    logic [4:0]            unmasked;

    assign unmasked = i_exception & i_trap_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            trap_q       <= 1'b0;
            trap_tag_q   <= '0;
            trap_flags_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept && (unmasked != 5'b0)) begin
                        state_q      <= ST_DRAIN;
                        trap_tag_q   <= i_tag;
                        trap_flags_q <= unmasked;
                    end
                end
                ST_DRAIN: begin
                    // Older results (including the faulting one) must leave first.
                    if (count_q == '0) begin
                        state_q <= ST_TRAP;
                        trap_q  <= 1'b1;
                    end
                end
                ST_TRAP: begin
                    if (i_trap_ack) begin
                        state_q <= ST_RUN;
                        trap_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    trap_q  <= 1'b0;
                end
            endcase
        end
    end

    assign run_ok       = (state_q == ST_RUN);
    assign o_trap       = trap_q;
    assign o_trap_tag   = trap_tag_q;
    assign o_trap_flags = trap_flags_q;
`else
    logic unused_trap_inputs;

    assign unused_trap_inputs = ^{i_trap_mask, i_trap_ack};
    assign run_ok             = 1'b1;
    assign o_trap             = 1'b0;
    assign o_trap_tag         = '0;
    assign o_trap_flags       = '0;
`endif

endmodule
